// File: rtl/router_ingress_arbiter.sv
// Store-and-forward ingress arbiter: round-robin picks one of three sources, buffers one whole
// packet, then replays it to the router with a trailing XOR parity byte. Port-3 packets are dropped.
module router_ingress_arbiter #(
  parameter int unsigned NSRC = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src_valid,
  input  logic [7:0]      src_data_0,
  input  logic [7:0]      src_data_1,
  input  logic [7:0]      src_data_2,
  output logic [NSRC-1:0] src_ready,
  output logic [NSRC-1:0] grant,
  input  logic            busy,
  output logic [7:0]      data_in,
  output logic            pkt_valid,
  output logic            pkt_sent,
  output logic            pkt_drop
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StSend   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StGap    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [NSRC-1:0] grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic [5:0]      load_ptr_q, load_ptr_d;
  logic [5:0]      send_ptr_q, send_ptr_d;
  logic [5:0]      len_q, len_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      parity_q, parity_d;
  logic [7:0]      mem [64];

  logic [7:0]      sel_data;
  logic            accept;
  logic            hdr_byte;
  logic [5:0]      cur_len;
  logic [1:0]      cur_addr;
  logic            last_byte;
  logic [1:0]      c0, c1, rr_idx;
  logic [NSRC-1:0] rr_grant;

  always_comb begin
    sel_data = 8'h00;
    unique case (grant_q)
      3'b001:  sel_data = src_data_0;
      3'b010:  sel_data = src_data_1;
      3'b100:  sel_data = src_data_2;
      default: sel_data = 8'h00;
    endcase
  end

  // Length and address come straight off the bus for the header byte itself.
  assign accept    = (state_q == StLoad) && |(src_valid & grant_q);
  assign hdr_byte  = (load_ptr_q == 6'd0);
  assign cur_len   = hdr_byte ? sel_data[7:2] : len_q;
  assign cur_addr  = hdr_byte ? sel_data[1:0] : addr_q;
  assign last_byte = accept && (load_ptr_q == cur_len);

  // Priority order after last_q: c0 first, c1 second, last_q itself last.
  always_comb begin
    c0     = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    c1     = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
    rr_idx = last_q;
    if (src_valid[c1]) rr_idx = c1;
    if (src_valid[c0]) rr_idx = c0;
    rr_grant = (|src_valid) ? (3'b001 << rr_idx) : 3'b000;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    load_ptr_d = load_ptr_q;
    send_ptr_d = send_ptr_q;
    len_d      = len_q;
    addr_d     = addr_q;
    parity_d   = parity_q;
    case (state_q)
      StIdle: begin
        load_ptr_d = 6'd0;
        if (|src_valid) begin
          grant_d = rr_grant;
          last_d  = rr_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          load_ptr_d = load_ptr_q + 6'd1;
          if (hdr_byte) begin
            len_d    = sel_data[7:2];
            addr_d   = sel_data[1:0];
            parity_d = sel_data;
          end else begin
            parity_d = parity_q ^ sel_data;
          end
          if (last_byte) begin
            if (cur_addr == 2'd3) begin
              state_d = StIdle;
              grant_d = '0;
            end else begin
              state_d    = StSend;
              send_ptr_d = 6'd0;
            end
          end
        end
      end
      StSend: begin
        if (!busy) begin
          if (send_ptr_q == len_q) state_d = StParity;
          else                     send_ptr_d = send_ptr_q + 6'd1;
        end
      end
      StParity: begin
        if (!busy) state_d = StGap;
      end
      StGap: begin
        state_d = StIdle;
        grant_d = '0;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_q     <= 2'd2;
      load_ptr_q <= 6'd0;
      send_ptr_q <= 6'd0;
      len_q      <= 6'd0;
      addr_q     <= 2'd0;
      parity_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      load_ptr_q <= load_ptr_d;
      send_ptr_q <= send_ptr_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      parity_q   <= parity_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem[load_ptr_q] <= sel_data;
  end

  always_comb begin
    data_in = 8'h00;
    if (state_q == StSend)        data_in = mem[send_ptr_q];
    else if (state_q == StParity) data_in = parity_q;
  end

  assign grant     = grant_q;
  assign src_ready = (state_q == StLoad) ? grant_q : '0;
  assign pkt_valid = (state_q == StSend);
  assign pkt_sent  = (state_q == StParity) && !busy;
  assign pkt_drop  = last_byte && (cur_addr == 2'd3);

endmodule
